// File: rtl/axi_read_arbiter.sv
// Round-robin arbiter sharing one AXI read channel among N_REQ requesters, one burst in flight.
// Latency: grant to m_arvalid 1 cycle; R path combinational; backpressure: owner's req_rready drives m_rready.
module axi_read_arbiter #(
  parameter int N_REQ  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_arvalid,
  input  logic [N_REQ*ADDR_W-1:0] req_araddr,
  input  logic [N_REQ*4-1:0]      req_arlen,
  input  logic [N_REQ*3-1:0]      req_arsize,
  output logic [N_REQ-1:0]        req_arready,
  output logic [N_REQ-1:0]        req_rvalid,
  input  logic [N_REQ-1:0]        req_rready,
  output logic [DATA_W-1:0]       req_rdata,
  output logic                    req_rlast,
  output logic [1:0]              req_rresp,
  output logic                    m_arvalid,
  output logic [ADDR_W-1:0]       m_araddr,
  output logic [3:0]              m_arlen,
  output logic [2:0]              m_arsize,
  output logic [3:0]              m_arid,
  output logic [1:0]              m_arburst,
  input  logic                    m_arready,
  input  logic                    m_rvalid,
  input  logic [DATA_W-1:0]       m_rdata,
  input  logic [1:0]              m_rresp,
  input  logic                    m_rlast,
  output logic                    m_rready,
  output logic                    busy,
  output logic                    len_err
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [PTR_W:0]   N_EXT = (PTR_W+1)'(N_REQ);
  localparam logic [PTR_W-1:0] LAST  = PTR_W'(N_REQ - 1);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t           state;
  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] owner;
  logic [PTR_W-1:0] win;
  logic             win_vld;
  logic [PTR_W:0]   idx;
  logic [3:0]       beat_cnt;

  logic [ADDR_W-1:0] addr_a [N_REQ];
  logic [3:0]        len_a  [N_REQ];
  logic [2:0]        size_a [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign addr_a[g] = req_araddr[g*ADDR_W +: ADDR_W];
    assign len_a[g]  = req_arlen[g*4 +: 4];
    assign size_a[g] = req_arsize[g*3 +: 3];
    assign req_arready[g] = (state == ADDR) && m_arready && (owner == PTR_W'(g));
    assign req_rvalid[g]  = (state == DATA) && m_rvalid && (owner == PTR_W'(g));
  end

  // First asserted requester at or after rr_ptr, wrapping.
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    idx     = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = {1'b0, rr_ptr} + (PTR_W+1)'(k);
      if (idx >= N_EXT) idx = idx - N_EXT;
      if (!win_vld && req_arvalid[idx[PTR_W-1:0]]) begin
        win_vld = 1'b1;
        win     = idx[PTR_W-1:0];
      end
    end
  end

  assign m_rready  = (state == DATA) && req_rready[owner];
  assign req_rdata = m_rdata;
  assign req_rresp = m_rresp;
  assign req_rlast = m_rlast;
  assign m_arid    = 4'd0;
  assign m_arburst = 2'b01;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      owner     <= '0;
      m_arvalid <= 1'b0;
      m_araddr  <= '0;
      m_arlen   <= '0;
      m_arsize  <= '0;
      beat_cnt  <= '0;
      busy      <= 1'b0;
      len_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (win_vld) begin
          owner     <= win;
          m_araddr  <= addr_a[win];
          m_arlen   <= len_a[win];
          m_arsize  <= size_a[win];
          rr_ptr    <= (win == LAST) ? '0 : win + 1'b1;
          m_arvalid <= 1'b1;
          busy      <= 1'b1;
          state     <= ADDR;
        end
        ADDR: if (m_arready) begin
          m_arvalid <= 1'b0;
          beat_cnt  <= '0;
          state     <= DATA;
        end
        DATA: if (m_rvalid && m_rready) begin
          beat_cnt <= beat_cnt + 4'd1;
          if (m_rlast) begin
            // beat_cnt counts beats before this one, so a full burst ends at arlen.
            if (beat_cnt != m_arlen) len_err <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
